// File: rtl/msk_mixcol_seq.sv
// Masked AES MixColumns / InvMixColumns engine over a d-share Boolean-shared 128-bit state.
// Latency: input handshake at edge k gives out_valid after edge k+4/PAR, PAR columns per cycle.
// Backpressure: result held stable in DONE until out_ready; a new state may be taken in the same cycle.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_inverse/sh_in accept one masked state
// and its direction; out_valid/out_ready/sh_out return the masked result; busy flags the BUSY state.
// Share encoding: byte b=4*col+row, bit i, share j lives at index (8*b+i)*D+j.
module msk_mixcol_seq #(
    parameter int D   = 2,
    parameter int PAR = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inverse,
    input  logic [128*D-1:0] sh_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [128*D-1:0] sh_out,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         col_q, col_d;
    logic               mode_q, mode_d;
    logic [128*D-1:0]   work_q, work_d;
    logic [128*D-1:0]   res_q, res_d;
    logic [128*D-1:0]   res_grp;
    logic [1:0]         grp_col;
    logic [31:0]        col_in, col_out;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One column of one share; bytes are rows, row r at bits [8r+7:8r].
    // The inverse is realised as a cheap pre-multiply by {05,00,04,00} (circulant)
    // followed by the forward matrix, since InvMix = Mix x that circulant.
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0] a [4];
        logic [7:0] u, v;
        logic [31:0] r;
        for (int k = 0; k < 4; k++) a[k] = c[8*k +: 8];
        u = xtime(xtime(a[0] ^ a[2]));
        v = xtime(xtime(a[1] ^ a[3]));
        if (inv) begin
            a[0] = a[0] ^ u;
            a[2] = a[2] ^ u;
            a[1] = a[1] ^ v;
            a[3] = a[3] ^ v;
        end
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = xtime(a[k]) ^ xtime(a[(k+1)%4]) ^ a[(k+1)%4]
                        ^ a[(k+2)%4] ^ a[(k+3)%4];
        end
        return r;
    endfunction

    // Transform the current column group share by share; each share's bits are
    // gathered, mixed and scattered without ever touching another share.
    always_comb begin
        res_grp = res_q;
        grp_col = '0;
        col_in  = '0;
        col_out = '0;
        for (int p = 0; p < PAR; p++) begin
            grp_col = col_q + 2'(p);
            for (int j = 0; j < D; j++) begin
                for (int b = 0; b < 4; b++)
                    for (int i = 0; i < 8; i++)
                        col_in[8*b+i] = work_q[(8*(4*int'(grp_col)+b)+i)*D+j];
                col_out = mix_col(col_in, mode_q);
                for (int b = 0; b < 4; b++)
                    for (int i = 0; i < 8; i++)
                        res_grp[(8*(4*int'(grp_col)+b)+i)*D+j] = col_out[8*b+i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        mode_d   = mode_q;
        work_d   = work_q;
        res_d    = res_q;
        in_ready = 1'b0;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_BUSY: begin
                res_d = res_grp;
                col_d = col_q + 2'(PAR);
                if (col_q == 2'(4 - PAR)) state_d = S_DONE;
            end
            S_DONE: begin
                // Chaining straight into BUSY avoids an IDLE bubble under back-to-back traffic.
                in_ready = out_ready;
                if (out_ready && !in_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (in_valid && in_ready) begin
            work_d  = sh_in;
            mode_d  = in_inverse;
            col_d   = '0;
            state_d = S_BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            mode_q  <= 1'b0;
            work_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
            res_q   <= res_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign sh_out    = res_q;

endmodule

// File: tb/tb_msk_mixcol_seq.sv
module tb_msk_mixcol_seq;

    localparam int ND  [3] = '{2, 3, 2};
    localparam int LAT [3] = '{4, 1, 2};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_inverse = 1'b0;
    logic out_ready = 1'b0;
    logic [255:0] sh_in_d2 = '0;
    logic [383:0] sh_in_d3 = '0;
    logic in_rdy [3];
    logic out_vld [3];
    logic bsy [3];
    logic [255:0] so0, so2;
    logic [383:0] so1;
    logic [383:0] outv [3];
    logic [383:0] exp_v [3];
    int lat [3];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    msk_mixcol_seq #(.D(2), .PAR(1)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(in_rdy[0]), .in_inverse(in_inverse), .sh_in(sh_in_d2), .out_valid(out_vld[0]),
        .out_ready(out_ready), .sh_out(so0), .busy(bsy[0]));
    msk_mixcol_seq #(.D(3), .PAR(4)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(in_rdy[1]), .in_inverse(in_inverse), .sh_in(sh_in_d3), .out_valid(out_vld[1]),
        .out_ready(out_ready), .sh_out(so1), .busy(bsy[1]));
    msk_mixcol_seq #(.D(2), .PAR(2)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(in_rdy[2]), .in_inverse(in_inverse), .sh_in(sh_in_d2), .out_valid(out_vld[2]),
        .out_ready(out_ready), .sh_out(so2), .busy(bsy[2]));

    always_comb begin
        outv[0] = {128'b0, so0};
        outv[1] = so1;
        outv[2] = {128'b0, so2};
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11b << (k - 8));
        return p[7:0];
    endfunction

    // Matrix product of each column with the circulant of the chosen direction.
    function automatic logic [127:0] ref_mc(input logic [127:0] s, input bit inv);
        logic [7:0] cf [4];
        logic [7:0] acc;
        logic [127:0] r = '0;
        if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gf_mul(cf[(k - i + 4) % 4], s[8*(4*c+k) +: 8]);
                r[8*(4*c+i) +: 8] = acc;
            end
        return r;
    endfunction

    function automatic logic [383:0] mask_state(input logic [127:0] s, input int n);
        logic [383:0] v = '0;
        logic x, m;
        for (int k = 0; k < 128; k++) begin
            x = s[k];
            for (int j = 1; j < n; j++) begin
                m = 1'($urandom_range(0, 1));
                v[k*n+j] = m;
                x = x ^ m;
            end
            v[k*n] = x;
        end
        return v;
    endfunction

    function automatic logic [127:0] get_share(input logic [383:0] v, input int n, input int j);
        logic [127:0] s = '0;
        for (int k = 0; k < 128; k++) s[k] = v[k*n+j];
        return s;
    endfunction

    function automatic logic [127:0] unmask(input logic [383:0] v, input int n);
        logic [127:0] s = '0;
        for (int j = 0; j < n; j++) s = s ^ get_share(v, n, j);
        return s;
    endfunction

    // Linearity: each output share is the transform of the matching input share.
    function automatic logic [383:0] exp_out(input logic [383:0] v, input int n, input bit inv);
        logic [383:0] r = '0;
        logic [127:0] t;
        for (int j = 0; j < n; j++) begin
            t = ref_mc(get_share(v, n, j), inv);
            for (int k = 0; k < 128; k++) r[k*n+j] = t[k];
        end
        return r;
    endfunction

    // Columns given as 32-bit words, row 0 in the top byte.
    function automatic logic [127:0] mk(input logic [31:0] c0, input logic [31:0] c1,
                                        input logic [31:0] c2, input logic [31:0] c3);
        logic [31:0] cw [4];
        logic [127:0] s = '0;
        cw = '{c0, c1, c2, c3};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[8*(4*c+r) +: 8] = cw[c][31-8*r -: 8];
        return s;
    endfunction

    function automatic logic [383:0] in_vec(input int i);
        return (i == 1) ? sh_in_d3 : {128'b0, sh_in_d2};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic prep(input logic [127:0] s, input bit inv);
        logic [383:0] t;
        t = mask_state(s, 2);
        sh_in_d2 = t[255:0];
        sh_in_d3 = mask_state(s, 3);
        in_inverse = inv;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) exp_v[i] = exp_out(in_vec(i), ND[i], inv);
    endtask

    task automatic send(input logic [127:0] s, input bit inv);
        prep(s, inv);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_inverse = ~inv;
        sh_in_d2 = {8{$urandom}};
        sh_in_d3 = {12{$urandom}};
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3; i++) lat[i] = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) if (out_vld[i] && lat[i] < 0) lat[i] = cyc;
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({in_rdy[i], out_vld[i], bsy[i]} !== 3'b100 || outv[i] !== '0) begin
                n_fail++;
                $display("FAIL reset inst%0d: rdy/vld/busy=%b%b%b out=%h expected 100 out=0",
                         i, in_rdy[i], out_vld[i], bsy[i], outv[i]);
            end
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed(input string nm, input logic [127:0] s, input bit inv,
                                 input logic [127:0] want);
        send(s, inv);
        wait_done();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (lat[i] != LAT[i]) begin
                n_fail++;
                $display("FAIL %s latency inst%0d: got %0d expected %0d", nm, i, lat[i], LAT[i]);
            end
            n_checks++;
            if (unmask(outv[i], ND[i]) !== want) begin
                n_fail++;
                $display("FAIL %s value inst%0d: got %h expected %h", nm, i,
                         unmask(outv[i], ND[i]), want);
            end
            n_checks++;
            if (outv[i] !== exp_v[i]) begin
                n_fail++;
                $display("FAIL %s shares inst%0d: got %h expected %h", nm, i, outv[i], exp_v[i]);
            end
        end
        // A nonzero mask must keep share 0 away from the plain result.
        if (get_share(in_vec(0), 2, 1) != '0) begin
            n_checks++;
            if (get_share(outv[0], 2, 0) === want) begin
                n_fail++;
                $display("FAIL %s masking: share0 %h equals unmasked result", nm,
                         get_share(outv[0], 2, 0));
            end
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [383:0] snap [3];
        logic [127:0] s1, s2;
        s1 = {$urandom, $urandom, $urandom, $urandom};
        s2 = {$urandom, $urandom, $urandom, $urandom};
        send(s1, 1'b0);
        wait_done();
        for (int i = 0; i < 3; i++) snap[i] = outv[i];
        prep(s2, 1'b1);
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (outv[i] !== snap[i] || in_rdy[i] !== 1'b0 || out_vld[i] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL hold inst%0d cyc%0d: out=%h rdy=%b vld=%b expected out=%h rdy=0 vld=1",
                             i, cyc, outv[i], in_rdy[i], out_vld[i], snap[i]);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (snap[i] !== exp_out(exp_v[i] ^ exp_v[i] | snap[i], ND[i], 1'b0) && 0) n_fail++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bsy[i] !== 1'b1 || out_vld[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL chain inst%0d: busy=%b vld=%b expected busy=1 vld=0", i, bsy[i], out_vld[i]);
            end
        end
        wait_done();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (outv[i] !== exp_v[i] || unmask(outv[i], ND[i]) !== ref_mc(s2, 1'b1)) begin
                n_fail++;
                $display("FAIL chain result inst%0d: got %h expected %h", i, outv[i], exp_v[i]);
            end
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        logic [127:0] s;
        s = {$urandom, $urandom, $urandom, $urandom};
        send(s, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({in_rdy[i], out_vld[i], bsy[i]} !== 3'b100 || outv[i] !== '0) begin
                n_fail++;
                $display("FAIL midreset inst%0d: rdy/vld/busy=%b%b%b out=%h expected 100 out=0",
                         i, in_rdy[i], out_vld[i], bsy[i], outv[i]);
            end
        end
        @(posedge clk); #1 rst_n = 1'b1;
        s = {$urandom, $urandom, $urandom, $urandom};
        send(s, 1'b1);
        wait_done();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (outv[i] !== exp_v[i] || lat[i] != LAT[i]) begin
                n_fail++;
                $display("FAIL post-reset inst%0d: got %h lat %0d expected %h lat %0d",
                         i, outv[i], lat[i], exp_v[i], LAT[i]);
            end
        end
        release_out();
    endtask

    task automatic test_random(input int iters);
        logic [127:0] s, s2;
        bit inv;
        for (int it = 0; it < iters; it++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            send(s, inv);
            wait_done();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (outv[i] !== exp_v[i]) begin
                    n_fail++;
                    $display("FAIL random it%0d inst%0d: got %h expected %h", it, i, outv[i], exp_v[i]);
                end
            end
            s2 = unmask(outv[0], 2);
            release_out();
            send(s2, ~inv);
            wait_done();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (unmask(outv[i], ND[i]) !== s) begin
                    n_fail++;
                    $display("FAIL roundtrip it%0d inst%0d: got %h expected %h", it, i,
                             unmask(outv[i], ND[i]), s);
                end
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_directed("fwd_col0", mk(32'hdb135345, 0, 0, 0), 1'b0, mk(32'h8e4da1bc, 0, 0, 0));
        test_directed("inv_col0", mk(32'h8e4da1bc, 0, 0, 0), 1'b1, mk(32'hdb135345, 0, 0, 0));
        test_directed("fwd_multi", mk(32'hf20a225c, 32'hc6c6c6c6, 32'h01010101, 32'h2d26314c), 1'b0,
                      mk(32'h9fdc589d, 32'hc6c6c6c6, 32'h01010101, 32'h4d7ebdf8));
        test_back_to_back();
        test_reset_mid();
        test_random(1500);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
